// File: rtl/arb_mux_pkg.sv
// Shared helpers for arb_mux: index-width function and a channel-index type.
// The optional burst-lock feature of arb_mux is selected with ARB_MUX_LOCK_EN.
package arb_mux_pkg;

    // Index width that never collapses to zero bits for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Wide enough for any practical NUM_CH; consumers narrow to SEL_W as needed.
    localparam int CH_IDX_MAX_W = 8;
    typedef logic [CH_IDX_MAX_W-1:0] ch_idx_t;

    function automatic ch_idx_t to_ch_idx(input int unsigned ch);
        return ch_idx_t'(ch);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: first set request after base, wrapping,
// with base itself examined last. Reusable by any round-robin arbiter.
module rr_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic [W-1:0] idx,
    output logic         vld
);

    logic [W-1:0] cand;

    always_comb begin
        idx  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int i = 1; i <= N; i++) begin
            cand = W'((int'(base) + i) % N);
            if (!vld && req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// Registered N-channel round-robin mux with valid/ready handshake.
// Define ARB_MUX_LOCK_EN to add lock_i, letting the last granted channel hold the grant.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 8,
    parameter int SEL_W      = clog2_min1(NUM_CH)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_CH-1:0]            valid_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
    output logic [NUM_CH-1:0]            ready_o,
`ifdef ARB_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]            lock_i,
`endif
    output logic                         valid_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [SEL_W-1:0]             ch_o,
    input  logic                         ready_i
);

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] beats;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_vld;
    logic [SEL_W-1:0] pick;
    logic             pick_vld;
    logic             slot_free;
    logic             xfer;

    assign beats     = data_i;
    assign slot_free = !valid_o || ready_i;

    rr_pick #(.N(NUM_CH), .W(SEL_W)) u_pick (
        .req  (valid_i),
        .base (ptr),
        .idx  (rr_idx),
        .vld  (rr_vld)
    );

`ifdef ARB_MUX_LOCK_EN
    // A locked, still-valid owner keeps the grant; otherwise fall back to round-robin.
    logic hold;
    assign hold     = lock_i[ptr] && valid_i[ptr];
    assign pick     = hold ? ptr : rr_idx;
    assign pick_vld = hold || rr_vld;
`else
    assign pick     = rr_idx;
    assign pick_vld = rr_vld;
`endif

    always_comb begin
        ready_o = '0;
        if (!rst_i && slot_free && pick_vld)
            ready_o[pick] = 1'b1;
    end

    assign xfer = |(valid_i & ready_o);

    // Drain and refill share one edge, so back-to-back beats leave no bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            ch_o    <= '0;
            ptr     <= SEL_W'(NUM_CH - 1);
        end else if (xfer) begin
            valid_o <= 1'b1;
            data_o  <= beats[pick];
            ch_o    <= pick;
            ptr     <= pick;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: directed scenarios plus randomized traffic
// against a queue-free behavioural model of the round-robin rules.
module tb_arb_mux;

`ifdef ARB_MUX_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   valid;
    logic [255:0] data;
    logic [7:0]   rdy;
    logic [7:0]   lock;
    logic         out_vld;
    logic [31:0]  out_data;
    logic [2:0]   out_ch;
    logic         dn_rdy;

    logic [4:0]   valid5;
    logic [159:0] data5;
    logic [4:0]   rdy5;
    logic         out_vld5;
    logic [31:0]  out_data5;
    logic [2:0]   out_ch5;
    logic         dn_rdy5;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: what the output register should hold and who was granted last.
    int          m_ptr;
    bit          m_vld;
    logic [31:0] m_data;
    int          m_ch;
    logic [7:0]  e_rdy;

    always #5 clk = ~clk;

    arb_mux #(.DATA_WIDTH(32), .NUM_CH(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid),
        .data_i  (data),
        .ready_o (rdy),
`ifdef ARB_MUX_LOCK_EN
        .lock_i  (lock),
`endif
        .valid_o (out_vld),
        .data_o  (out_data),
        .ch_o    (out_ch),
        .ready_i (dn_rdy)
    );

    arb_mux #(.DATA_WIDTH(32), .NUM_CH(5)) dut5 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid5),
        .data_i  (data5),
        .ready_o (rdy5),
`ifdef ARB_MUX_LOCK_EN
        .lock_i  (5'b0),
`endif
        .valid_o (out_vld5),
        .data_o  (out_data5),
        .ch_o    (out_ch5),
        .ready_i (dn_rdy5)
    );

    function automatic logic [7:0] model_ready(input logic [7:0] v, input logic [7:0] lk,
                                               input bit dn, input bit r);
        int g;
        model_ready = '0;
        g = -1;
        if (r || (m_vld && !dn)) return model_ready;
        if (LOCK_EN && lk[m_ptr] && v[m_ptr]) g = m_ptr;
        for (int i = 1; i <= 8; i++)
            if (g < 0 && v[(m_ptr + i) % 8]) g = (m_ptr + i) % 8;
        if (g >= 0) model_ready[g] = 1'b1;
        return model_ready;
    endfunction

    task automatic model_reset();
        m_ptr = 7; m_vld = 0; m_data = '0; m_ch = 0;
    endtask

    // Let the combinational outputs settle and compute the model's expected grant.
    task automatic settle();
        #1;
        e_rdy = model_ready(valid, lock, dn_rdy, rst);
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (rst) model_reset();
        else if (|(valid & e_rdy)) begin
            for (int g = 0; g < 8; g++)
                if (e_rdy[g]) begin
                    m_data = data[g*32 +: 32]; m_ch = g; m_ptr = g; m_vld = 1;
                end
        end else if (dn_rdy) m_vld = 0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1; valid = '0; valid5 = '0; lock = '0; dn_rdy = 1; dn_rdy5 = 1;
        settle();
        edge_step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; valid = 8'hFF; valid5 = 5'h1F; dn_rdy = 1; dn_rdy5 = 1; lock = '0;
        data = '1; data5 = '1;
        for (int c = 0; c < 2; c++) begin
            settle();
            n_chk++; if (rdy !== 8'h00) begin n_err++; $display("FAIL reset_ready got=%h exp=00", rdy); end
            n_chk++; if (rdy5 !== 5'h00) begin n_err++; $display("FAIL reset_ready5 got=%h exp=00", rdy5); end
            edge_step();
            n_chk++; if ({out_vld, out_data, out_ch} !== {1'b0, 32'h0, 3'd0}) begin
                n_err++; $display("FAIL reset_out got=%b/%h/%0d exp=0/0/0", out_vld, out_data, out_ch); end
            n_chk++; if (out_vld5 !== 1'b0) begin n_err++; $display("FAIL reset_out5 got=%b exp=0", out_vld5); end
        end
        rst = 0; valid = '0; valid5 = '0;
    endtask

    task automatic test_single();
        do_reset();
        valid = 8'h01; data = '0; data[31:0] = 32'hA5A5A5A5; dn_rdy = 1;
        settle();
        n_chk++; if (rdy !== 8'h01) begin n_err++; $display("FAIL single_ready got=%h exp=01", rdy); end
        edge_step();
        valid = '0;
        n_chk++; if ({out_vld, out_data, out_ch} !== {1'b1, 32'hA5A5A5A5, 3'd0}) begin
            n_err++; $display("FAIL single_out got=%b/%h/%0d exp=1/a5a5a5a5/0", out_vld, out_data, out_ch); end
        settle();
        edge_step();
        n_chk++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL single_drain got=%b exp=0", out_vld); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        valid = 8'hFF; dn_rdy = 1;
        for (int k = 0; k < 8; k++) data[k*32 +: 32] = 32'h100 + k;
        for (int c = 0; c < 9; c++) begin
            settle();
            n_chk++; if (rdy !== 8'(1 << (c % 8))) begin
                n_err++; $display("FAIL b2b_ready c=%0d got=%h exp=%h", c, rdy, 8'(1 << (c % 8))); end
            edge_step();
            n_chk++; if ({out_vld, out_ch, out_data} !== {1'b1, 3'(c % 8), 32'h100 + 32'(c % 8)}) begin
                n_err++; $display("FAIL b2b_out c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, out_vld, out_ch,
                                  out_data, c % 8, 32'h100 + 32'(c % 8)); end
        end
        valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 8; k++) data[k*32 +: 32] = 32'h300 + k;
        valid = 8'h08; dn_rdy = 1;
        settle(); edge_step();
        valid = 8'h30; dn_rdy = 0;
        for (int c = 0; c < 4; c++) begin
            settle();
            n_chk++; if (rdy !== 8'h00) begin n_err++; $display("FAIL bp_ready c=%0d got=%h exp=00", c, rdy); end
            edge_step();
            n_chk++; if ({out_vld, out_ch, out_data} !== {1'b1, 3'd3, 32'h303}) begin
                n_err++; $display("FAIL bp_hold c=%0d got=%b/%0d/%h exp=1/3/303", c, out_vld, out_ch, out_data); end
        end
        dn_rdy = 1;
        for (int c = 0; c < 2; c++) begin
            settle();
            n_chk++; if (rdy !== 8'(8'h10 << c)) begin
                n_err++; $display("FAIL bp_release_ready c=%0d got=%h exp=%h", c, rdy, 8'(8'h10 << c)); end
            edge_step();
            n_chk++; if (out_ch !== 3'(4 + c)) begin
                n_err++; $display("FAIL bp_release_ch c=%0d got=%0d exp=%0d", c, out_ch, 4 + c); end
        end
        valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid = 8'h10; dn_rdy = 1;
        settle(); edge_step();
        valid = '0; dn_rdy = 0;
        settle(); edge_step();
        rst = 1; valid = 8'h44;
        settle();
        n_chk++; if (rdy !== 8'h00) begin n_err++; $display("FAIL rstmid_ready got=%h exp=00", rdy); end
        edge_step();
        rst = 0;
        n_chk++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rstmid_vld got=%b exp=0", out_vld); end
        dn_rdy = 1;
        settle();
        n_chk++; if (rdy !== 8'h04) begin n_err++; $display("FAIL rstmid_grant got=%h exp=04", rdy); end
        edge_step();
        n_chk++; if (out_ch !== 3'd2) begin n_err++; $display("FAIL rstmid_ch got=%0d exp=2", out_ch); end
        valid = '0;
    endtask

    task automatic test_wrap5();
        do_reset();
        for (int k = 0; k < 5; k++) data5[k*32 +: 32] = 32'h500 + k;
        valid5 = 5'b10000; dn_rdy5 = 1;
        #1; @(posedge clk); #1;
        n_chk++; if (out_ch5 !== 3'd4) begin n_err++; $display("FAIL wrap5_first got=%0d exp=4", out_ch5); end
        valid5 = 5'b10001;
        #1;
        n_chk++; if (rdy5 !== 5'b00001) begin n_err++; $display("FAIL wrap5_ready got=%b exp=00001", rdy5); end
        @(posedge clk); #1;
        n_chk++; if ({out_ch5, out_data5} !== {3'd0, 32'h500}) begin
            n_err++; $display("FAIL wrap5_wrap got=%0d/%h exp=0/500", out_ch5, out_data5); end
        @(posedge clk); #1;
        n_chk++; if ({out_vld5, out_ch5, out_data5} !== {1'b1, 3'd4, 32'h504}) begin
            n_err++; $display("FAIL wrap5_back got=%b/%0d/%h exp=1/4/504", out_vld5, out_ch5, out_data5); end
        valid5 = '0;
    endtask

    task automatic test_lock();
        do_reset();
        for (int k = 0; k < 8; k++) data[k*32 +: 32] = 32'h700 + k;
        valid = 8'h06; lock = 8'h02; dn_rdy = 1;
        for (int c = 0; c < 3; c++) begin
            settle(); edge_step();
            n_chk++; if (out_ch !== 3'd1) begin n_err++; $display("FAIL lock_hold c=%0d got=%0d exp=1", c, out_ch); end
        end
        lock = '0;
        settle(); edge_step();
        n_chk++; if (out_ch !== 3'd2) begin n_err++; $display("FAIL lock_release got=%0d exp=2", out_ch); end
        valid = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            valid  = 8'($urandom) & 8'($urandom | $urandom);
            lock   = 8'($urandom) & 8'($urandom);
            dn_rdy = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++) data[k*32 +: 32] = $urandom;
            settle();
            n_chk++; if (rdy !== e_rdy) begin
                n_err++; $display("FAIL rand_ready c=%0d got=%h exp=%h", c, rdy, e_rdy); end
            edge_step();
            n_chk++; if ({out_vld, out_ch, out_data} !== {m_vld, 3'(m_ch), m_data}) begin
                n_err++; $display("FAIL rand_out c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, out_vld, out_ch,
                                  out_data, m_vld, m_ch, m_data); end
        end
        valid = '0; lock = '0;
    endtask

    initial begin
        rst = 1; valid = '0; data = '0; lock = '0; dn_rdy = 0;
        valid5 = '0; data5 = '0; dn_rdy5 = 0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap5();
        if (LOCK_EN) test_lock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
